// File: rtl/div_arbiter.sv
// Two-port round-robin arbiter in front of a shared radix-2 restoring divider.
// Operands are captured at grant; done pulses one cycle to the granted port.
module div_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [WIDTH-1:0]  num0,
  input  logic [DWIDTH-1:0] den0,
  input  logic              req1,
  input  logic [WIDTH-1:0]  num1,
  input  logic [DWIDTH-1:0] den1,
  output logic              busy,
  output logic              gnt_id,
  output logic              done0,
  output logic              done1,
  output logic [WIDTH-1:0]  quotient,
  output logic [DWIDTH-1:0] remain,
  output logic              div_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  num_sh;
  logic [DWIDTH-1:0] den_q;
  logic [DWIDTH-1:0] rem;

  logic              any_req;
  logic              pick;
  logic [WIDTH-1:0]  win_num;
  logic [DWIDTH-1:0] win_den;
  logic              gnt_nxt;
  logic [DWIDTH:0]   trial;
  logic [DWIDTH-1:0] diff;
  logic              borrow;
  logic [DWIDTH-1:0] rem_step;
  logic [WIDTH-1:0]  num_step;
  logic              last_step;

  // Arbitration, one restoring step and next-state decode
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_id;
    any_req   = req0 | req1;
    pick      = (req0 & req1) ? ~last_grant : req1;
    win_num   = pick ? num1 : num0;
    win_den   = pick ? den1 : den0;
    trial     = {rem, num_sh[WIDTH-1]};
    diff      = trial[DWIDTH-1:0] - den_q;
    borrow    = (trial < {1'b0, den_q});
    rem_step  = borrow ? trial[DWIDTH-1:0] : diff;
    num_step  = {num_sh[WIDTH-2:0], ~borrow};
    last_step = (count == CW'(WIDTH - 1));

    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nxt   = pick;
          state_nxt = (win_den == '0) ? DONE : DIV;
        end
      end
      DIV: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= '0;
      num_sh     <= '0;
      den_q      <= '0;
      rem        <= '0;
      busy       <= 1'b0;
      gnt_id     <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      quotient   <= '0;
      remain     <= '0;
      div_zero   <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt != IDLE);
      gnt_id <= gnt_nxt;
      done0  <= (state_nxt == DONE) & ~gnt_nxt;
      done1  <= (state_nxt == DONE) & gnt_nxt;

      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= pick;
            num_sh     <= win_num;
            den_q      <= win_den;
            rem        <= '0;
            count      <= '0;
            if (win_den == '0) begin
              quotient <= '1;
              remain   <= '0;
              div_zero <= 1'b1;
            end
          end
        end
        DIV: begin
          rem    <= rem_step;
          num_sh <= num_step;
          count  <= count + CW'(1);
          if (last_step) begin
            quotient <= num_step;
            remain   <= rem_step;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed and randomized checks of div_arbiter arbitration, latency and results.
module tb_div_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] num0, num1;
  logic [3:0] den0, den1;
  logic       busy, gnt_id, done0, done1, div_zero;
  logic [7:0] quotient;
  logic [3:0] remain;

  int  vectors = 0;
  int  miscompares = 0;
  bit  lg;
  int  req_cnt0 = 0, req_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;

  always #5 clk = ~clk;

  div_arbiter #(.WIDTH(8), .DWIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .num0(num0), .den0(den0),
    .req1(req1), .num1(num1), .den1(den1),
    .busy(busy), .gnt_id(gnt_id), .done0(done0), .done1(done1),
    .quotient(quotient), .remain(remain), .div_zero(div_zero)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-port operation; lat counts edges from the first sampling edge (grant) to done visible.
  task automatic run_op(input bit p, input int unsigned n, input int unsigned d,
                        input int unsigned elat, input int unsigned eq,
                        input int unsigned er, input int unsigned ez);
    int lat;
    bit seen, other;
    if (p) begin req1 = 1'b1; num1 = 8'(n); den1 = 4'(d); end
    else   begin req0 = 1'b1; num0 = 8'(n); den0 = 4'(d); end
    tick();
    lat   = 1;
    check("busy_after_grant", busy, 1);
    seen  = p ? done1 : done0;
    other = p ? done0 : done1;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      seen  = p ? done1 : done0;
      other = other | (p ? done0 : done1);
    end
    check("latency", lat, elat);
    check("gnt_id", gnt_id, p);
    check("quotient", quotient, eq);
    check("remain", remain, er);
    check("div_zero", div_zero, ez);
    check("other_done", other, 0);
    if (p) req1 = 1'b0; else req0 = 1'b0;
    tick();
    check("done_cleared", p ? done1 : done0, 0);
    check("idle_busy", busy, 0);
    lg = p;
  endtask

  // Issue requests on the ports in mask and complete each against the reference model.
  task automatic serve(input bit [1:0] mask, input int unsigned n0, input int unsigned d0,
                       input int unsigned n1, input int unsigned d1);
    bit [1:0] pend;
    bit       first;
    int unsigned exp_first;
    exp_first = (mask == 2'b11) ? int'(!lg) : ((mask == 2'b01) ? 0 : 1);
    if (mask[0]) begin req0 = 1'b1; num0 = 8'(n0); den0 = 4'(d0); req_cnt0++; end
    if (mask[1]) begin req1 = 1'b1; num1 = 8'(n1); den1 = 4'(d1); req_cnt1++; end
    pend  = mask;
    first = 1'b1;
    for (int t = 0; t < 60 && pend != 2'b00; t++) begin
      tick();
      if (done0) begin
        check("rnd_p0_pending", pend[0], 1);
        if (first) check("rnd_order", 0, exp_first);
        check("rnd_q0", quotient, n0 / d0);
        check("rnd_r0", remain, n0 % d0);
        done_cnt0++;
        req0 = 1'b0; pend[0] = 1'b0; lg = 1'b0; first = 1'b0;
      end
      if (done1) begin
        check("rnd_p1_pending", pend[1], 1);
        if (first) check("rnd_order", 1, exp_first);
        check("rnd_q1", quotient, n1 / d1);
        check("rnd_r1", remain, n1 % d1);
        done_cnt1++;
        req1 = 1'b0; pend[1] = 1'b0; lg = 1'b1; first = 1'b0;
      end
    end
    check("rnd_timeout", pend, 0);
    tick();
  endtask

  initial begin
    int  got;
    bit  hit;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    num0 = '0; den0 = '0; num1 = '0; den1 = '0;
    lg = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_gnt", gnt_id, 0);
    check("rst_done", {done0, done1}, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remain, 0);
    check("rst_dz", div_zero, 0);
    tick();

    // Basic operations on each port
    run_op(1'b0, 19, 5, 9, 3, 4, 0);
    run_op(1'b1, 255, 15, 9, 17, 0, 0);
    run_op(1'b1, 200, 1, 9, 200, 0, 0);

    // Simultaneous request after reset, both held: grants alternate 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0; lg = 1'b1;
    req0 = 1'b1; num0 = 8'd100; den0 = 4'd7;
    req1 = 1'b1; num1 = 8'd50;  den1 = 4'd3;
    for (int k = 0; k < 4; k++) begin
      hit = 1'b0;
      for (int t = 0; t < 20 && !hit; t++) begin
        tick();
        hit = done0 | done1;
      end
      check("alt_seen", hit, 1);
      got = done1 ? 1 : 0;
      check("alt_port", got, k % 2);
      check("alt_q", quotient, (k % 2) ? 16 : 14);
      check("alt_r", remain, 2);
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
    tick();
    check("alt_idle", busy, 0);
    lg = 1'b1;

    // Divide by zero, then a normal op clears the flag
    run_op(1'b0, 77, 0, 1, 255, 0, 1);
    run_op(1'b1, 100, 7, 9, 14, 2, 0);

    // Reset at DIV step 4 aborts the operation
    req0 = 1'b1; num0 = 8'd200; den0 = 4'd3;
    tick();
    repeat (4) tick();
    check("pre_abort_busy", busy, 1);
    rst = 1'b1; req0 = 1'b0;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", {done0, done1}, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remain, 0);
    check("abort_gnt", gnt_id, 0);
    hit = 1'b0;
    repeat (10) begin tick(); hit = hit | done0 | done1; end
    check("abort_no_done", hit, 0);
    lg = 1'b1;
    serve(2'b11, 200, 3, 9, 4);

    // Randomized interleaving of both ports
    for (int i = 0; i < 300; i++) begin
      serve(2'($urandom_range(1, 3)),
            $urandom_range(0, 255), $urandom_range(1, 15),
            $urandom_range(0, 255), $urandom_range(1, 15));
    end
    check("done_count0", done_cnt0, req_cnt0);
    check("done_count1", done_cnt1, req_cnt1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
